stopwatch_timebase: RTL and testbench

- Upstream time source for the 4-digit FND controller.
- Generates a 100 Hz tick from the 100 MHz system clock and runs cascaded counters: centiseconds 0-99, seconds 0-59, minutes 0-59, hours 0-23.
- Run/stop/clear control FSM is driven by single-cycle button pulses from the debouncer stage.
- Outputs feed the FND controller directly: msec goes to bcd_low (LOW_MAX=100), sec goes to bcd_high (HIGH_MAX=60).

---
 rtl/stopwatch_timebase.sv | 219 +++++++++++++++++++++
 tb/tb_stopwatch_timebase.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: 100 Hz tick generator feeding cascaded centisecond/second/minute/hour counters under a run/stop/clear FSM.
// Latency: counters update on the edge that samples the tick; the first increment lands TICK_COUNT cycles after RUN is entered.
// Backpressure: none; single-cycle button pulses are always consumed. Optional lap-hold output freeze under `STOPWATCH_LAP_EN.
module stopwatch_timebase #(
  parameter int TICK_COUNT = 1_000_000,
  parameter int MSEC_MAX   = 100,
  parameter int SEC_MAX    = 60,
  parameter int MIN_MAX    = 60,
  parameter int HOUR_MAX   = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_btn_run,
  input  logic                        i_btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic                        i_btn_lap,
  output logic                        o_lap_hold,
`endif
  output logic [$clog2(MSEC_MAX)-1:0] o_msec,
  output logic [$clog2(SEC_MAX)-1:0]  o_sec,
  output logic [$clog2(MIN_MAX)-1:0]  o_min,
  output logic [$clog2(HOUR_MAX)-1:0] o_hour,
  output logic                        o_running
);

  localparam int MSEC_W = $clog2(MSEC_MAX);
  localparam int SEC_W  = $clog2(SEC_MAX);
  localparam int MIN_W  = $clog2(MIN_MAX);
  localparam int HOUR_W = $clog2(HOUR_MAX);
  localparam int TICK_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [MSEC_W-1:0] MSEC_LAST = MSEC_W'(MSEC_MAX - 1);
  localparam logic [MSEC_W-1:0] MSEC_ONE  = MSEC_W'(1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX - 1);
  localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_MAX - 1);
  localparam logic [MIN_W-1:0]  MIN_ONE   = MIN_W'(1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);
  localparam logic [HOUR_W-1:0] HOUR_ONE  = HOUR_W'(1);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic              running_q,  running_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [MSEC_W-1:0] msec_q,     msec_d;
  logic [SEC_W-1:0]  sec_q,      sec_d;
  logic [MIN_W-1:0]  min_q,      min_d;
  logic [HOUR_W-1:0] hour_q,     hour_d;

  logic tick;
  logic msec_wrap;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // Control FSM: clear beats run in STOP; CLEAR is a single-cycle pass-through back to STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (i_btn_clear) begin
          state_d = ST_CLEAR;
        end else if (i_btn_run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_btn_run) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  // Tick strobe and per-digit wrap detection; the tick is qualified by RUN so a stopped counter never fires.
  always_comb begin
    tick      = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
    msec_wrap = (msec_q == MSEC_LAST);
    sec_wrap  = (sec_q == SEC_LAST);
    min_wrap  = (min_q == MIN_LAST);
    hour_wrap = (hour_q == HOUR_LAST);
  end

  // Tick prescaler and cascaded time counters; every carry resolves in the tick edge itself.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    case (state_q)
      ST_CLEAR: begin
        tick_cnt_d = '0;
        msec_d     = '0;
        sec_d      = '0;
        min_d      = '0;
        hour_d     = '0;
      end
      ST_RUN: begin
        // A stop pulse on the tick cycle does not suppress this increment.
        tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_ONE);
        if (tick) begin
          msec_d = msec_wrap ? '0 : (msec_q + MSEC_ONE);
          if (msec_wrap) begin
            sec_d = sec_wrap ? '0 : (sec_q + SEC_ONE);
            if (sec_wrap) begin
              min_d = min_wrap ? '0 : (min_q + MIN_ONE);
              if (min_wrap) begin
                hour_d = hour_wrap ? '0 : (hour_q + HOUR_ONE);
              end
            end
          end
        end
      end
      default: begin
        // STOP keeps the partial tick period so a resume loses no phase.
        tick_cnt_d = tick_cnt_q;
      end
    endcase
  end

  // State, prescaler and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_STOP;
      running_q  <= 1'b0;
      tick_cnt_q <= '0;
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      tick_cnt_q <= tick_cnt_d;
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
    end
  end

  assign o_running = running_q;

`ifdef STOPWATCH_LAP_EN
  logic              lap_hold_q, lap_hold_d;
  logic [MSEC_W-1:0] lap_msec_q, lap_msec_d;
  logic [SEC_W-1:0]  lap_sec_q,  lap_sec_d;
  logic [MIN_W-1:0]  lap_min_q,  lap_min_d;
  logic [HOUR_W-1:0] lap_hour_q, lap_hour_d;

  // Lap toggle only while staying in RUN; leaving RUN drops the hold. Snapshot takes the values written on the lap edge.
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_msec_d = lap_msec_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;
    if (state_d != ST_RUN) begin
      lap_hold_d = 1'b0;
    end else if ((state_q == ST_RUN) && i_btn_lap) begin
      lap_hold_d = !lap_hold_q;
      if (!lap_hold_q) begin
        lap_msec_d = msec_d;
        lap_sec_d  = sec_d;
        lap_min_d  = min_d;
        lap_hour_d = hour_d;
      end
    end
  end

  // Lap hold flag and snapshot registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_hold_q <= 1'b0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_msec_q <= lap_msec_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
    end
  end

  // Display mux: frozen snapshot while holding, live counters otherwise.
  always_comb begin
    o_lap_hold = lap_hold_q;
    o_msec     = lap_hold_q ? lap_msec_q : msec_q;
    o_sec      = lap_hold_q ? lap_sec_q  : sec_q;
    o_min      = lap_hold_q ? lap_min_q  : min_q;
    o_hour     = lap_hold_q ? lap_hour_q : hour_q;
  end
`else
  // Display is always the live counters.
  always_comb begin
    o_msec = msec_q;
    o_sec  = sec_q;
    o_min  = min_q;
    o_hour = hour_q;
  end
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase: drives a full-size and a shrunken-modulus stopwatch with directed and random button pulses.
// Latency: each step applies one input vector, waits one clock edge and compares against a total-centisecond reference model.
// Backpressure: none; optional lap checks are compiled in with STOPWATCH_LAP_EN.
module tb_stopwatch_timebase;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic btn_run;
  logic btn_clear;
`ifdef STOPWATCH_LAP_EN
  logic btn_lap;
  logic a_lap_hold;
  logic b_lap_hold;
`endif

  logic [6:0] a_msec;
  logic [5:0] a_sec;
  logic [5:0] a_min;
  logic [4:0] a_hour;
  logic       a_running;

  logic [1:0] b_msec;
  logic [1:0] b_sec;
  logic [1:0] b_min;
  logic [0:0] b_hour;
  logic       b_running;

  stopwatch_timebase #(
    .TICK_COUNT(4), .MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_btn_run   (btn_run),
    .i_btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
    .i_btn_lap   (btn_lap),
    .o_lap_hold  (a_lap_hold),
`endif
    .o_msec      (a_msec),
    .o_sec       (a_sec),
    .o_min       (a_min),
    .o_hour      (a_hour),
    .o_running   (a_running)
  );

  stopwatch_timebase #(
    .TICK_COUNT(2), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)
  ) u_dut_small (
    .clk         (clk),
    .reset       (reset),
    .i_btn_run   (btn_run),
    .i_btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
    .i_btn_lap   (btn_lap),
    .o_lap_hold  (b_lap_hold),
`endif
    .o_msec      (b_msec),
    .o_sec       (b_sec),
    .o_min       (b_min),
    .o_hour      (b_hour),
    .o_running   (b_running)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed time as one centisecond total, run/clear mode flags, prescaler phase.
  int tc[2]  = '{4, 2};
  int ms[2]  = '{100, 4};
  int sc[2]  = '{60, 3};
  int mn[2]  = '{60, 3};
  int hr[2]  = '{24, 2};
  bit m_run[2]  = '{1'b0, 1'b0};
  bit m_clr[2]  = '{1'b0, 1'b0};
  bit m_hold[2] = '{1'b0, 1'b0};
  int phase[2]  = '{0, 0};
  int total[2]  = '{0, 0};
  int snap[2]   = '{0, 0};

  task automatic model_step(input int i, input bit rn, input bit r, input bit c, input bit l);
    bit tick;
    bit nrun;
    bit nclr;
    if (!rn) begin
      m_run[i] = 1'b0; m_clr[i] = 1'b0; m_hold[i] = 1'b0;
      phase[i] = 0; total[i] = 0; snap[i] = 0;
      return;
    end
    tick = m_run[i] && (phase[i] == tc[i] - 1);
    if (m_clr[i]) begin
      nrun = 1'b0; nclr = 1'b0;
    end else if (m_run[i]) begin
      nrun = !r; nclr = 1'b0;
    end else begin
      nclr = c; nrun = !c && r;
    end
    if (m_clr[i]) begin
      phase[i] = 0; total[i] = 0;
    end else if (m_run[i]) begin
      phase[i] = tick ? 0 : phase[i] + 1;
      if (tick) total[i] = (total[i] + 1) % (ms[i] * sc[i] * mn[i] * hr[i]);
    end
    if (!nrun) begin
      m_hold[i] = 1'b0;
    end else if (LAP && m_run[i] && l) begin
      m_hold[i] = !m_hold[i];
      snap[i]   = total[i];
    end
    m_run[i] = nrun;
    m_clr[i] = nclr;
  endtask

  task automatic compare_all();
    int s0;
    int s1;
    s0 = m_hold[0] ? snap[0] : total[0];
    s1 = m_hold[1] ? snap[1] : total[1];
    chk("a_msec", a_msec, s0 % ms[0]);
    chk("a_sec",  a_sec,  (s0 / ms[0]) % sc[0]);
    chk("a_min",  a_min,  (s0 / (ms[0] * sc[0])) % mn[0]);
    chk("a_hour", a_hour, s0 / (ms[0] * sc[0] * mn[0]));
    chk("a_running", a_running, m_run[0]);
    chk("b_msec", b_msec, s1 % ms[1]);
    chk("b_sec",  b_sec,  (s1 / ms[1]) % sc[1]);
    chk("b_min",  b_min,  (s1 / (ms[1] * sc[1])) % mn[1]);
    chk("b_hour", b_hour, s1 / (ms[1] * sc[1] * mn[1]));
    chk("b_running", b_running, m_run[1]);
`ifdef STOPWATCH_LAP_EN
    chk("a_lap_hold", a_lap_hold, m_hold[0]);
    chk("b_lap_hold", b_lap_hold, m_hold[1]);
`endif
  endtask

  task automatic step(input bit rn, input bit r, input bit c, input bit l);
    reset     = rn;
    btn_run   = r;
    btn_clear = c;
`ifdef STOPWATCH_LAP_EN
    btn_lap   = l;
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, rn, r, c, l);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; btn_run = 1'b0; btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_msec", a_msec, 0);
    chk("rst_running", a_running, 0);

    // First increments and cascade into seconds and minutes.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("run_running", a_running, 1);
    idle(4);
    chk("first_msec", a_msec, 1);
    idle(4);
    chk("second_msec", a_msec, 2);
    chk("second_sec", a_sec, 0);
    idle(98 * 4);
    chk("wrap_msec", a_msec, 0);
    chk("wrap_sec", a_sec, 1);
    idle(5900 * 4);
    chk("min_min", a_min, 1);
    chk("min_sec", a_sec, 0);

    // Stop with prescaler at 2, resume, increment after two clocks.
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(50);
    chk("stopped_msec", a_msec, 0);
    chk("stopped_running", a_running, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("resume1_msec", a_msec, 0);
    idle(1);
    chk("resume2_msec", a_msec, 1);

    // Clear ignored in RUN; clear wins over run in STOP.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_in_run", a_running, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clear_running", a_running, 0);
    idle(1);
    chk("cleared_min", a_min, 0);
    chk("cleared_msec", a_msec, 0);
    chk("cleared_running", a_running, 0);

    // Reset while running at 00:00:05.37.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(537 * 4);
    chk("t537_sec", a_sec, 5);
    chk("t537_msec", a_msec, 37);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_run_msec", a_msec, 0);
    chk("rst_run_running", a_running, 0);

    // Full rollover on the shrunken instance: 1:2:2.3 -> 0:0:0.0 in one tick.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(142);
    chk("small_max_hour", b_hour, 1);
    chk("small_max_msec", b_msec, 3);
    idle(2);
    chk("small_roll_hour", b_hour, 0);
    chk("small_roll_min", b_min, 0);
    chk("small_roll_msec", b_msec, 0);

`ifdef STOPWATCH_LAP_EN
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(48);
    chk("lap_pre_msec", a_msec, 12);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("lap_hold_on", a_lap_hold, 1);
    idle(32);
    chk("lap_frozen_msec", a_msec, 12);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("lap_release_msec", a_msec, 20);
    chk("lap_hold_off", a_lap_hold, 0);
`endif

    // Random button traffic with rare resets.
    for (int k = 0; k < 15000; k++) begin
      step($urandom_range(0, 1999) != 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
